// File: rtl/sat_engine_pkg.sv
// Shared SAT-engine types: clause-array controller state encoding and limits.
// Imported by every block of the engine that needs the controller's view.
package sat_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_IMPLY   = 3'd2,
        ST_ANALYZE = 3'd3,
        ST_BKT     = 3'd4
    } ctrl_state_t;

    localparam int MAX_ITER_DEF = 255;
    localparam int ITER_W       = 8;

endpackage

// File: rtl/row_onehot_dec.sv
// Row index to one-hot clause-row select.
// Latency: combinational.
// Backpressure: none; pure decode.
module row_onehot_dec #(
    parameter int NUM_C = 8,
    parameter int CNT_W = 3
) (
    input  logic [CNT_W-1:0] cnt,
    output logic [NUM_C-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_C; i++) begin
            onehot[i] = (cnt == CNT_W'(i));
        end
    end

endmodule

// File: rtl/clause_array_ctrl.sv
// Sequencer for the clause array: row load, BCP to fixpoint, conflict analysis, backtrack.
// Latency: strobes combinational from state; done/conflict pulses one cycle after the deciding cycle.
// Backpressure: load_valid_i gaps stall LOAD; requests are only accepted in IDLE.
module clause_array_ctrl
    import sat_engine_pkg::*;
#(
    parameter int NUM_C     = 8,
    parameter int WIDTH_LVL = 16,
    parameter int MAX_ITER  = MAX_ITER_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start_i,
    input  logic                 load_valid_i,
    output logic                 load_ready_o,
    output logic [NUM_C-1:0]     wr_o,
    output logic                 load_done_o,
    input  logic                 imply_req_i,
    input  logic                 changed_i,
    input  logic                 conflict_i,
    output logic                 apply_imply_o,
    output logic                 apply_analyze_o,
    output logic                 apply_bkt_o,
    output logic                 imply_done_o,
    output logic                 conflict_o,
    input  logic                 analyze_done_i,
    input  logic                 bkt_req_i,
    input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
    output logic [WIDTH_LVL-1:0] bkt_lvl_o,
    output logic                 busy_o,
    output logic                 watchdog_o
);

    localparam int                ROW_W     = (NUM_C > 1) ? $clog2(NUM_C) : 1;
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_C - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

    ctrl_state_t       state, state_nxt;
    logic [ROW_W-1:0]  row_cnt, row_nxt;
    logic [ITER_W-1:0] iter_cnt, iter_nxt;
    logic              load_done_nxt, imply_done_nxt, conflict_nxt, wdog_set, bkt_take;
    logic [NUM_C-1:0]  row_oh;

    row_onehot_dec #(.NUM_C(NUM_C), .CNT_W(ROW_W)) u_row_dec (
        .cnt    (row_cnt),
        .onehot (row_oh)
    );

    always_comb begin
        state_nxt      = state;
        row_nxt        = row_cnt;
        iter_nxt       = iter_cnt;
        load_done_nxt  = 1'b0;
        imply_done_nxt = 1'b0;
        conflict_nxt   = 1'b0;
        wdog_set       = 1'b0;
        bkt_take       = 1'b0;
        case (state)
            ST_IDLE: begin
                row_nxt  = '0;
                iter_nxt = '0;
                if (load_start_i) begin
                    state_nxt = ST_LOAD;
                end else if (bkt_req_i) begin
                    state_nxt = ST_BKT;
                    bkt_take  = 1'b1;
                end else if (imply_req_i) begin
                    state_nxt = ST_IMPLY;
                end
            end
            ST_LOAD: begin
                if (load_valid_i) begin
                    if (row_cnt == ROW_LAST) begin
                        row_nxt       = '0;
                        load_done_nxt = 1'b1;
                        state_nxt     = ST_IDLE;
                    end else begin
                        row_nxt = row_cnt + 1'b1;
                    end
                end
            end
            ST_IMPLY: begin
                iter_nxt = iter_cnt + 1'b1;
                // Conflict beats a fresh implication; a clean fixpoint beats the watchdog.
                if (conflict_i) begin
                    conflict_nxt = 1'b1;
                    state_nxt    = ST_ANALYZE;
                end else if (!changed_i) begin
                    imply_done_nxt = 1'b1;
                    state_nxt      = ST_IDLE;
                end else if (iter_cnt == ITER_LAST) begin
                    wdog_set  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ANALYZE: begin
                if (analyze_done_i) state_nxt = ST_IDLE;
            end
            ST_BKT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            row_cnt      <= '0;
            iter_cnt     <= '0;
            load_ready_o <= 1'b0;
            load_done_o  <= 1'b0;
            imply_done_o <= 1'b0;
            conflict_o   <= 1'b0;
            busy_o       <= 1'b0;
            watchdog_o   <= 1'b0;
            bkt_lvl_o    <= '0;
        end else begin
            state        <= state_nxt;
            row_cnt      <= row_nxt;
            iter_cnt     <= iter_nxt;
            load_ready_o <= (state_nxt == ST_LOAD);
            load_done_o  <= load_done_nxt;
            imply_done_o <= imply_done_nxt;
            conflict_o   <= conflict_nxt;
            busy_o       <= (state_nxt != ST_IDLE);
            if (wdog_set) watchdog_o <= 1'b1;
            if (bkt_take) bkt_lvl_o  <= bkt_lvl_i;
        end
    end

    assign wr_o            = (state == ST_LOAD && load_valid_i) ? row_oh : '0;
    assign apply_imply_o   = (state == ST_IMPLY);
    assign apply_analyze_o = (state == ST_ANALYZE);
    assign apply_bkt_o     = (state == ST_BKT);

endmodule

// File: doc/clause_array_ctrl.md
CLAUSE_ARRAY_CTRL -- requirements
Module: clause_array_ctrl

Interface
REQ-001 Parameter NUM_C, default 8: clause rows in the array.
REQ-002 Parameter WIDTH_LVL, default 16: decision-level width.
REQ-003 Parameter MAX_ITER, default 255: implication-round watchdog limit; counter width 8.
REQ-004 clk  in  1  clock; rst  in  1  reset, synchronous, active-low.
REQ-005 load_start_i  in  1  pulse: begin loading NUM_C clause rows.
REQ-006 load_valid_i  in  1 / load_ready_o  out  1  row-data handshake.
REQ-007 wr_o  out  NUM_C  one-hot row write strobe to the lit cells.
REQ-008 load_done_o  out  1  one-cycle pulse after the last row.
REQ-009 imply_req_i  in  1  pulse: run BCP to fixpoint.
REQ-010 changed_i  in  1  array reports a new implication this cycle; conflict_i  in  1  any clause conflict.
REQ-011 apply_imply_o, apply_analyze_o, apply_bkt_o  out  1 each  array control strobes.
REQ-012 imply_done_o  out  1  pulse: fixpoint, no conflict; conflict_o  out  1  pulse: conflict found.
REQ-013 analyze_done_i  in  1  analysis finished; bkt_req_i  in  1  pulse; bkt_lvl_i  in  WIDTH_LVL  target level; bkt_lvl_o  out  WIDTH_LVL.
REQ-014 busy_o  out  1  state != IDLE; watchdog_o  out  1  sticky iteration-limit error.

Function
REQ-015 States SHALL be IDLE, LOAD, IMPLY, ANALYZE, BKT; one state register.
REQ-016 IDLE priority SHALL be load_start_i > bkt_req_i > imply_req_i; lower-priority requests in the same cycle are dropped.
REQ-017 LOAD: load_ready_o=1; each cycle with load_valid_i asserts wr_o bit = row counter and increments it.
REQ-018 Row counter reaching NUM_C-1 with load_valid_i SHALL pulse load_done_o the next cycle and return to IDLE; counter clears.
REQ-019 Gaps in load_valid_i SHALL stall LOAD without writing; wr_o=0 then.
REQ-020 IMPLY: apply_imply_o=1 every cycle in state; iteration counter increments each cycle.
REQ-021 conflict_i in IMPLY SHALL win over changed_i: next cycle conflict_o pulses, state ANALYZE.
REQ-022 changed_i=0 and conflict_i=0 in IMPLY SHALL pulse imply_done_o next cycle and return to IDLE; minimum latency 2 cycles from imply_req_i.
REQ-023 Iteration counter reaching MAX_ITER SHALL set watchdog_o, return to IDLE, without imply_done_o.
REQ-024 ANALYZE: apply_analyze_o=1 each cycle until analyze_done_i, then IDLE.
REQ-025 BKT: bkt_lvl_o latched from bkt_lvl_i on accept; apply_bkt_o=1 for exactly one cycle; then IDLE.
REQ-026 At most one of apply_imply_o, apply_analyze_o, apply_bkt_o, any wr_o bit SHALL be high per cycle.
REQ-027 Requests outside IDLE SHALL be ignored.

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE, clear counters, bkt_lvl_o=0, watchdog_o=0, all strobes and pulses 0, load_ready_o=0.
REQ-029 Reset mid-LOAD or mid-IMPLY SHALL abandon the operation with no done pulse.
REQ-030 watchdog_o SHALL clear only by reset.

Structure
REQ-031 State encoding enum and MAX_ITER default SHALL live in the shared sat_engine package.
REQ-032 Row one-hot decoder SHALL be sub-module row_onehot_dec (counter in, NUM_C-bit one-hot out).
REQ-033 All outputs registered except wr_o and apply_* strobes, decoded from state and counter.

Verification
REQ-034 Load 8 rows with a valid gap at row 3 -> wr_o walks 0x01..0x80, holds 0 in gap; load_done_o one cycle after row 7.
REQ-035 imply_req_i, changed_i=1 for 3 cycles then 0 -> apply_imply_o high 4 cycles; imply_done_o pulse; no conflict_o.
REQ-036 IMPLY with conflict_i=1 and changed_i=1 same cycle -> conflict_o pulse; apply_analyze_o until analyze_done_i.
REQ-037 bkt_req_i with bkt_lvl_i=5 -> bkt_lvl_o=5, apply_bkt_o exactly one cycle.
REQ-038 changed_i held 1 with MAX_ITER=4 -> watchdog_o=1 after 4 rounds; IDLE; no imply_done_o.
REQ-039 rst=0 during LOAD at row 4 -> IDLE next cycle; no load_done_o; next load restarts at wr_o=0x01.
